// File: rtl/counter_ctrl.sv
// Start/stop/load counter controller with a latched terminal count and one-cycle TC pulse.
// Define COUNTER_CTRL_AUTORELOAD_EN to wrap to 0 and keep running at terminal count.
module counter_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      limit_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
    end
  end

  // Every branch honours stop > start > load by testing them in that order.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    tc_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
          count_d = '0;
          limit_d = limit;
        end else if (load) begin
          count_d = load_val;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else if (count_q == limit_q) begin
          tc_d = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
          count_d = '0;
`else
          state_d = StDone;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (start) begin
          state_d = StRun;
        end else if (load) begin
          count_d = load_val;
        end
      end
      StDone: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (start) begin
          state_d = StRun;
          count_d = '0;
          limit_d = limit;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign state = state_q;
  assign busy  = (state_q == StRun) || (state_q == StPause);

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_counter_ctrl;
  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0, limit = '0;
  logic [W-1:0] count;
  logic         tc, busy;
  logic [1:0]   state;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .count(count), .tc(tc), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tc;
    int busy;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: state name as an int, 0=idle 1=run 2=pause 3=done.
  int m_st = 0, m_cnt = 0, m_lim = 0, m_tc = 0;

  task automatic check(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit l, input int lv, input int lim);
    m_tc = 0;
    case (m_st)
      0: if (!p) begin
        if (s) begin m_st = 1; m_cnt = 0; m_lim = lim; end
        else if (l) m_cnt = lv;
      end
      1: if (p) m_st = 2;
         else if (m_cnt == m_lim) begin
           m_tc = 1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
           m_cnt = 0;
`else
           m_st = 3;
`endif
         end else m_cnt = (m_cnt + 1) % MOD;
      2: if (p) begin m_st = 0; m_cnt = 0; end
         else if (s) m_st = 1;
         else if (l) m_cnt = lv;
      default: if (p) begin m_st = 0; m_cnt = 0; end
               else if (s) begin m_st = 1; m_cnt = 0; m_lim = lim; end
    endcase
  endtask

  task automatic cycle(input bit s, input bit p, input bit l, input int lv, input int lim);
    exp_t e;
    @(negedge clk);
    start = s; stop = p; load = l;
    load_val = W'(lv); limit = W'(lim);
    model_step(s, p, l, lv, lim);
    e.cnt = m_cnt; e.tc = m_tc; e.busy = (m_st == 1 || m_st == 2) ? 1 : 0; e.st = m_st;
    exp_q.push_back(e);
  endtask

  // Idle cycles wiggle LIMIT to show it only matters on a start edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, $urandom_range(MOD - 1), $urandom_range(MOD - 1));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    start = 0; stop = 0; load = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst count", int'(count), 0);
    check("rst state", int'(state), 0);
    check("rst tc", int'(tc), 0);
    check("rst busy", int'(busy), 0);
    m_st = 0; m_cnt = 0; m_lim = 0; m_tc = 0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle, so compare once per edge whenever an entry is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.cnt);
        check("tc", int'(tc), e.tc);
        check("busy", int'(busy), e.busy);
        check("state", int'(state), e.st);
      end
    end
  end

  initial begin
    #3;
    check("por count", int'(count), 0);
    check("por state", int'(state), 0);
    check("por tc", int'(tc), 0);
    check("por busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run to terminal count 3.
    cycle(1, 0, 0, 0, 3);
    idle(7);
    // Start and stop together in idle/done, then limit change mid-run.
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 1, 7, 5);
    cycle(1, 0, 0, 0, 3);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 8);
    // Pause at 4, load 9, resume with limit 15.
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 15);
    idle(4);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 9, 0);
    cycle(1, 0, 0, 0, 0);
    idle(9);
    // Zero limit.
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(4);
    // Load above limit forces a wrap through 0.
    cycle(1, 0, 0, 0, 2);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 14, 0);
    cycle(1, 0, 0, 0, 0);
    idle(6);
    // Loads ignored in run and done, honoured in idle.
    cycle(0, 0, 1, 6, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 11, 0);
    cycle(1, 0, 1, 4, 2);
    cycle(0, 0, 1, 5, 0);
    idle(4);
    // Asynchronous reset mid-run at count 5.
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 10);
    idle(5);
    reset_pulse();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) reset_pulse();
      else cycle($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(9) == 0,
                 $urandom_range(MOD - 1), $urandom_range(MOD - 1));
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    check("queue drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  begin, resume or restart counting.
REQ-005 STOP  input  1  pause a run, or abort to idle.
REQ-006 LOAD  input  1  preset COUNT from LOAD_VAL.
REQ-007 LOAD_VAL  input  WIDTH  preset value.
REQ-008 LIMIT  input  WIDTH  terminal count, sampled on start.
REQ-009 COUNT  output  WIDTH  current count, registered.
REQ-010 TC  output  1  terminal-count pulse, registered, one cycle wide.
REQ-011 BUSY  output  1  high while STATE is RUN or PAUSE.
REQ-012 STATE  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE, all evaluated on the rising edge of CLK.
REQ-014 When STOP, START and LOAD are asserted together, the block SHALL apply the priority STOP > START > LOAD; the lower-priority inputs are ignored in that cycle.
REQ-015 IDLE: START SHALL move the FSM to RUN, set COUNT to 0 and latch LIMIT into limit_reg; LOAD SHALL set COUNT to LOAD_VAL; STOP SHALL do nothing.
REQ-016 RUN: at each edge, if COUNT == limit_reg, the block SHALL set TC to 1 for exactly the next cycle and apply the terminal action (REQ-027/028); otherwise COUNT SHALL become COUNT+1 modulo 2^WIDTH.
REQ-017 RUN: STOP SHALL move the FSM to PAUSE with COUNT held, and SHALL take precedence over the terminal action.
REQ-018 RUN: START and LOAD SHALL be ignored.
REQ-019 PAUSE: START SHALL return the FSM to RUN without changing COUNT or limit_reg; LOAD SHALL set COUNT to LOAD_VAL; STOP SHALL move the FSM to IDLE with COUNT cleared to 0.
REQ-020 DONE: COUNT SHALL hold; START SHALL behave as in IDLE (RUN, COUNT=0, re-latch LIMIT); STOP SHALL move the FSM to IDLE with COUNT=0; LOAD SHALL be ignored.
REQ-021 A change on LIMIT outside a start edge SHALL have no effect.
REQ-022 With limit_reg=0, TC SHALL assert on the cycle after the first RUN edge.
REQ-023 If COUNT > limit_reg after a LOAD, counting SHALL wrap from 2^WIDTH-1 to 0 and continue until COUNT equals limit_reg.
REQ-024 TC SHALL be 0 in every cycle not covered by REQ-016.
REQ-025 BUSY SHALL be decoded combinationally from the state register only.

Reset
REQ-026 While RST_N=0, the block SHALL immediately and asynchronously force STATE=IDLE, COUNT=0, TC=0, BUSY=0 and limit_reg=0, including in the middle of a run; after RST_N rises, the first CLK edge SHALL act as IDLE.

Configuration
REQ-027 The macro COUNTER_CTRL_AUTORELOAD_EN, when defined, SHALL make the RUN terminal action set COUNT to 0 and keep the FSM in RUN, so TC pulses every limit_reg+1 cycles.
REQ-028 When COUNTER_CTRL_AUTORELOAD_EN is undefined, the RUN terminal action SHALL move the FSM to DONE with COUNT held at limit_reg.

Verification (WIDTH=4)
REQ-029 No macro, LIMIT=3, one-cycle START from IDLE -> COUNT 0,1,2,3; one TC pulse; STATE=3 with COUNT=3 held; BUSY=0.
REQ-030 Macro defined, LIMIT=2, START -> COUNT 0,1,2,0,1,2,...; TC pulse every 3 cycles; STATE stays 1.
REQ-031 RUN at COUNT=4, STOP -> STATE=2, COUNT=4; LOAD, LOAD_VAL=9 -> COUNT=9; START with limit_reg=15 -> COUNT 10..15, then TC.
REQ-032 START and STOP in the same cycle in IDLE -> STATE stays 0; LIMIT changed from 3 to 8 mid-run -> TC still fires at COUNT=3.
REQ-033 RST_N driven low asynchronously at COUNT=5 in RUN -> COUNT=0, STATE=0, TC=0 before the next CLK edge.
REQ-034 LIMIT=0, START -> exactly one RUN edge, then TC=1 for one cycle and STATE=3 (no macro).
